// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: FSM state encodings
// and default counter width / memory-wait timeout.
package pipe_ctrl_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_MEM_TIMEOUT = 64;
    // MEM_TIMEOUT is at most 255, so the wait counter never needs more bits.
    localparam int WAIT_CNT_W      = 8;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline write-enable / flush controller for the 5-stage core: enforces
// memory freezes, branch flushes and load-use stalls, with a bounded memory wait.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             Hazard_i,
    input  logic             Branch_taken_i,
    input  logic             Mem_req_i,
    input  logic             Mem_ready_i,
    output logic             PC_write_o,
    output logic             IF_ID_write_o,
    output logic             IF_ID_flush_o,
    output logic             ID_EX_flush_o,
    output logic             EX_MEM_write_o,
    output logic             MEM_WB_bubble_o,
    output logic             Mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  timeout_hit;
    logic                  mem_stall;
    logic                  stall_en;
    logic                  flush_en;

    // Memory handshake: Mem_req_i flags a load/store sitting in MEM; the access
    // completes in the first cycle Mem_ready_i is high and is held until then.
    assign timeout_hit = (state_q == ST_MEM_WAIT) && (wait_cnt_q == WAIT_LAST);
    assign mem_stall   = Mem_req_i & ~Mem_ready_i & ~timeout_hit;

    always_comb begin
        PC_write_o      = 1'b1;
        IF_ID_write_o   = 1'b1;
        IF_ID_flush_o   = 1'b0;
        ID_EX_flush_o   = 1'b0;
        EX_MEM_write_o  = 1'b1;
        MEM_WB_bubble_o = timeout_hit;
        Mem_err_o       = timeout_hit;
        if (!rst_i) begin
            PC_write_o      = 1'b0;
            IF_ID_write_o   = 1'b0;
            IF_ID_flush_o   = 1'b1;
            ID_EX_flush_o   = 1'b1;
            EX_MEM_write_o  = 1'b0;
            MEM_WB_bubble_o = 1'b1;
            Mem_err_o       = 1'b0;
        end else if (mem_stall) begin
            PC_write_o      = 1'b0;
            IF_ID_write_o   = 1'b0;
            EX_MEM_write_o  = 1'b0;
            MEM_WB_bubble_o = 1'b1;
        end else if (Branch_taken_i) begin
            // A stalled instruction behind a taken branch is wrong-path, so flush wins.
            IF_ID_flush_o = 1'b1;
            ID_EX_flush_o = 1'b1;
        end else if (Hazard_i) begin
            PC_write_o    = 1'b0;
            IF_ID_write_o = 1'b0;
            ID_EX_flush_o = 1'b1;
        end
    end

    always_comb begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
        if (mem_stall) begin
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = (state_q == ST_RUN) ? WAIT_CNT_W'(1) : wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign stall_en = rst_i & ~PC_write_o;
    assign flush_en = rst_i & ~mem_stall & Branch_taken_i;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (stall_en),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (flush_en),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: a default instance and a small one
// (CNT_W=3, MEM_TIMEOUT=4) share the same stimulus and are checked side by side.
module tb_pipe_stall_ctrl;
    import pipe_ctrl_pkg::*;

    // Control vector bit order: {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush,
    // EX_MEM_write, MEM_WB_bubble, Mem_err}.
    localparam logic [6:0] C_RESET  = 7'b0011010;
    localparam logic [6:0] C_IDLE   = 7'b1100100;
    localparam logic [6:0] C_FREEZE = 7'b0000010;
    localparam logic [6:0] C_BRANCH = 7'b1111100;
    localparam logic [6:0] C_HAZ    = 7'b0001100;
    localparam logic [6:0] C_TMO    = 7'b1100111;
    localparam logic [6:0] C_TMO_BR = 7'b1111111;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;
    logic hz = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;

    logic        a_pc, a_ifid_we, a_ifid_fl, a_idex_fl, a_exmem, a_bub, a_err;
    logic        b_pc, b_ifid_we, b_ifid_fl, b_idex_fl, b_exmem, b_bub, b_err;
    logic [15:0] a_stall, a_flush;
    logic [2:0]  b_stall, b_flush;
    logic [6:0]  ctrl_a, ctrl_b;

    assign ctrl_a = {a_pc, a_ifid_we, a_ifid_fl, a_idex_fl, a_exmem, a_bub, a_err};
    assign ctrl_b = {b_pc, b_ifid_we, b_ifid_fl, b_idex_fl, b_exmem, b_bub, b_err};

    pipe_stall_ctrl dut_a (
        .clk_i(clk), .rst_i(rst), .Hazard_i(hz), .Branch_taken_i(br),
        .Mem_req_i(req), .Mem_ready_i(rdy),
        .PC_write_o(a_pc), .IF_ID_write_o(a_ifid_we), .IF_ID_flush_o(a_ifid_fl),
        .ID_EX_flush_o(a_idex_fl), .EX_MEM_write_o(a_exmem), .MEM_WB_bubble_o(a_bub),
        .Mem_err_o(a_err), .stall_cnt_o(a_stall), .flush_cnt_o(a_flush)
    );

    pipe_stall_ctrl #(.CNT_W(3), .MEM_TIMEOUT(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .Hazard_i(hz), .Branch_taken_i(br),
        .Mem_req_i(req), .Mem_ready_i(rdy),
        .PC_write_o(b_pc), .IF_ID_write_o(b_ifid_we), .IF_ID_flush_o(b_ifid_fl),
        .ID_EX_flush_o(b_idex_fl), .EX_MEM_write_o(b_exmem), .MEM_WB_bubble_o(b_bub),
        .Mem_err_o(b_err), .stall_cnt_o(b_stall), .flush_cnt_o(b_flush)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [13:0] exp_q[$];
    logic [15:0] m_stall_a = '0, m_flush_a = '0;
    logic [2:0]  m_stall_b = '0, m_flush_b = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One cycle: drive inputs just after the edge, compare combinational controls
    // and the counters (which reflect earlier edges), then advance the counter model.
    task automatic cyc(input logic r, input logic h, input logic b, input logic q,
                       input logic y, input logic [6:0] ea, input logic [6:0] eb,
                       input string tag);
        logic [13:0] e;
        @(posedge clk);
        #1;
        rst = r; hz = h; br = b; req = q; rdy = y;
        exp_q.push_back({ea, eb});
        #1;
        e = exp_q.pop_front();
        check({tag, "/ctrl_a"}, 32'(ctrl_a), 32'(e[13:7]));
        check({tag, "/ctrl_b"}, 32'(ctrl_b), 32'(e[6:0]));
        check({tag, "/stall_a"}, 32'(a_stall), 32'(m_stall_a));
        check({tag, "/flush_a"}, 32'(a_flush), 32'(m_flush_a));
        check({tag, "/stall_b"}, 32'(b_stall), 32'(m_stall_b));
        check({tag, "/flush_b"}, 32'(b_flush), 32'(m_flush_b));
        if (!r) begin
            m_stall_a = '0; m_flush_a = '0; m_stall_b = '0; m_flush_b = '0;
        end else begin
            if (!ea[6] && m_stall_a != '1) m_stall_a = m_stall_a + 1'b1;
            if (ea[4]  && m_flush_a != '1) m_flush_a = m_flush_a + 1'b1;
            if (!eb[6] && m_stall_b != '1) m_stall_b = m_stall_b + 1'b1;
            if (eb[4]  && m_flush_b != '1) m_flush_b = m_flush_b + 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), C_RESET, C_RESET, "reset");
        end
        cyc(1'b1, 0, 0, 0, 0, C_IDLE, C_IDLE, "release");
        check("release/state_a", 32'(dut_a.state_q), 32'(ST_RUN));

        // Branch together with hazard: branch wins.
        cyc(1'b1, 1, 1, 0, 0, C_BRANCH, C_BRANCH, "br_hz");
        cyc(1'b1, 0, 0, 0, 0, C_IDLE, C_IDLE, "after_br");
        check("after_br/flush_a", 32'(a_flush), 32'd1);
        check("after_br/stall_a", 32'(a_stall), 32'd0);

        cyc(1'b1, 1, 0, 0, 0, C_HAZ, C_HAZ, "loaduse");
        cyc(1'b1, 0, 0, 0, 0, C_IDLE, C_IDLE, "after_lu");
        check("after_lu/stall_a", 32'(a_stall), 32'd1);

        // Four-cycle memory wait; the small instance times out on its 4th cycle.
        for (int i = 0; i < 3; i++) cyc(1'b1, 0, 0, 1, 0, C_FREEZE, C_FREEZE, "memwait");
        cyc(1'b1, 0, 0, 1, 0, C_FREEZE, C_TMO, "memwait4");
        cyc(1'b1, 0, 0, 1, 1, C_IDLE, C_IDLE, "memdone");
        check("memdone/state_a", 32'(dut_a.state_q), 32'(ST_MEM_WAIT));
        check("memdone/state_b", 32'(dut_b.state_q), 32'(ST_RUN));
        cyc(1'b1, 0, 0, 0, 0, C_IDLE, C_IDLE, "after_mem");
        check("after_mem/state_a", 32'(dut_a.state_q), 32'(ST_RUN));
        check("after_mem/stall_a", 32'(a_stall), 32'd5);

        // Ready already high in RUN: no stall, no state change.
        cyc(1'b1, 0, 0, 1, 1, C_IDLE, C_IDLE, "req_rdy");
        cyc(1'b1, 0, 0, 0, 0, C_IDLE, C_IDLE, "after_req_rdy");
        check("req_rdy/state_a", 32'(dut_a.state_q), 32'(ST_RUN));

        // Branch and hazard ignored under freeze, honoured once it ends.
        cyc(1'b1, 1, 1, 1, 0, C_FREEZE, C_FREEZE, "frz_br");
        cyc(1'b1, 1, 1, 1, 1, C_BRANCH, C_BRANCH, "frz_end_br");
        cyc(1'b1, 0, 0, 0, 0, C_IDLE, C_IDLE, "after_frz_br");
        check("after_frz_br/flush_a", 32'(a_flush), 32'd2);

        // Held timeout: error pulse, then a new wait starts.
        for (int i = 0; i < 3; i++) cyc(1'b1, 0, 0, 1, 0, C_FREEZE, C_FREEZE, "tmo");
        cyc(1'b1, 0, 0, 1, 0, C_FREEZE, C_TMO, "tmo_hit");
        cyc(1'b1, 0, 0, 1, 0, C_FREEZE, C_FREEZE, "tmo_rewait");
        check("tmo_rewait/state_b", 32'(dut_b.state_q), 32'(ST_RUN));
        check("tmo_rewait/wait_b", 32'(dut_b.wait_cnt_q), 32'd0);
        cyc(1'b1, 0, 0, 1, 1, C_IDLE, C_IDLE, "tmo_done");

        // Timeout cycle coinciding with a taken branch.
        for (int i = 0; i < 3; i++) cyc(1'b1, 0, 0, 1, 0, C_FREEZE, C_FREEZE, "tmo_br_wait");
        cyc(1'b1, 0, 1, 1, 0, C_FREEZE, C_TMO_BR, "tmo_br");
        cyc(1'b1, 0, 0, 1, 1, C_IDLE, C_IDLE, "tmo_br_done");

        // Saturation of the 3-bit stall counter.
        for (int i = 0; i < 10; i++) cyc(1'b1, 1, 0, 0, 0, C_HAZ, C_HAZ, "sat");
        cyc(1'b1, 0, 0, 0, 0, C_IDLE, C_IDLE, "after_sat");
        check("after_sat/stall_b", 32'(b_stall), 32'd7);

        // Reset lands on the small instance's timeout cycle: no error pulse.
        for (int i = 0; i < 3; i++) cyc(1'b1, 0, 0, 1, 0, C_FREEZE, C_FREEZE, "rst_wait");
        cyc(1'b0, 0, 0, 1, 0, C_RESET, C_RESET, "rst_mid");
        cyc(1'b1, 0, 0, 0, 0, C_IDLE, C_IDLE, "rst_release");
        check("rst_release/state_a", 32'(dut_a.state_q), 32'(ST_RUN));
        check("rst_release/state_b", 32'(dut_b.state_q), 32'(ST_RUN));
        cyc(1'b1, 0, 0, 0, 0, C_IDLE, C_IDLE, "final_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
